// File: rtl/pcm_udp_framer.sv
// Turns the packetiser's length-only header plus byte stream into a full UDP header
// and a length-checked payload stream; bad or disabled frames never stall upstream.
module pcm_udp_framer #(
  parameter int MAX_PAYLOAD = 1472,
  parameter int TIMEOUT     = 4095
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        s_hdr_valid,
  output logic        s_hdr_ready,
  input  logic [15:0] s_length,
  input  logic [7:0]  s_tdata,
  input  logic        s_tvalid,
  output logic        s_tready,
  input  logic        s_tlast,
  output logic        m_udp_hdr_valid,
  input  logic        m_udp_hdr_ready,
  output logic [31:0] m_ip_dest_ip,
  output logic [15:0] m_udp_source_port,
  output logic [15:0] m_udp_dest_port,
  output logic [15:0] m_udp_length,
  output logic [15:0] m_udp_checksum,
  output logic [7:0]  m_tdata,
  output logic        m_tvalid,
  input  logic        m_tready,
  output logic        m_tlast,
  output logic        m_tuser,
  input  logic        cfg_enable,
  input  logic [31:0] cfg_dest_ip,
  input  logic [15:0] cfg_dest_port,
  input  logic [15:0] cfg_src_port,
  output logic [31:0] stat_frames,
  output logic [15:0] stat_errors,
  output logic [15:0] stat_drops
);

  localparam int            TW     = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TO_MAX = TW'(TIMEOUT);
  localparam logic [15:0]   MAXP   = 16'(MAX_PAYLOAD);

  typedef enum logic [1:0] {IDLE, HDR, PAYLOAD, DRAIN} state_t;

  state_t        state_q, state_d;
  logic [31:0]   ip_q, ip_d;
  logic [15:0]   sport_q, sport_d;
  logic [15:0]   dport_q, dport_d;
  logic [15:0]   len_q, len_d;
  logic [15:0]   exp_q, exp_d;
  logic [15:0]   cnt_q, cnt_d;
  logic [TW-1:0] to_q, to_d;
  logic [31:0]   frames_q, frames_d;
  logic [15:0]   errors_q, errors_d;
  logic [15:0]   drops_q, drops_d;
  logic          last_pos;
  logic          timed_out;

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (&v) ? v : v + 32'd1;
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (&v) ? v : v + 16'd1;
  endfunction

  assign last_pos  = (cnt_q == exp_q - 16'd1);
  assign timed_out = (to_q == TO_MAX);

  always_comb begin
    state_d         = state_q;
    ip_d            = ip_q;
    sport_d         = sport_q;
    dport_d         = dport_q;
    len_d           = len_q;
    exp_d           = exp_q;
    cnt_d           = cnt_q;
    to_d            = to_q;
    frames_d        = frames_q;
    errors_d        = errors_q;
    drops_d         = drops_q;
    s_hdr_ready     = 1'b0;
    s_tready        = 1'b0;
    m_udp_hdr_valid = 1'b0;
    m_tdata         = 8'h00;
    m_tvalid        = 1'b0;
    m_tlast         = 1'b0;
    m_tuser         = 1'b0;
    case (state_q)
      IDLE: begin
        s_hdr_ready = 1'b1;
        if (s_hdr_valid) begin
          ip_d    = cfg_dest_ip;
          sport_d = cfg_src_port;
          dport_d = cfg_dest_port;
          len_d   = s_length;
          exp_d   = s_length - 16'd8;
          cnt_d   = 16'd0;
          if (!cfg_enable || (s_length < 16'd9) || ((s_length - 16'd8) > MAXP)) begin
            drops_d = sat_inc16(drops_q);
            state_d = DRAIN;
          end else begin
            state_d = HDR;
          end
        end
      end
      HDR: begin
        m_udp_hdr_valid = 1'b1;
        to_d            = '0;
        if (m_udp_hdr_ready) state_d = PAYLOAD;
      end
      PAYLOAD: begin
        s_tready = m_tready;
        if (s_tvalid) begin
          // A real byte always beats the timeout; tlast and the length limit decide the end.
          to_d     = '0;
          m_tvalid = 1'b1;
          m_tdata  = s_tdata;
          m_tlast  = s_tlast | last_pos;
          m_tuser  = s_tlast ^ last_pos;
          if (m_tready) begin
            cnt_d = cnt_q + 16'd1;
            if (s_tlast) begin
              if (last_pos) frames_d = sat_inc32(frames_q);
              else          errors_d = sat_inc16(errors_q);
              state_d = IDLE;
            end else if (last_pos) begin
              errors_d = sat_inc16(errors_q);
              state_d  = DRAIN;
            end
          end
        end else if (timed_out) begin
          m_tvalid = 1'b1;
          m_tlast  = 1'b1;
          m_tuser  = 1'b1;
          if (m_tready) begin
            errors_d = sat_inc16(errors_q);
            state_d  = DRAIN;
          end
        end else begin
          to_d = to_q + TW'(1);
        end
      end
      DRAIN: begin
        s_tready = 1'b1;
        if (s_tvalid && s_tlast) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      ip_q     <= '0;
      sport_q  <= '0;
      dport_q  <= '0;
      len_q    <= '0;
      exp_q    <= '0;
      cnt_q    <= '0;
      to_q     <= '0;
      frames_q <= '0;
      errors_q <= '0;
      drops_q  <= '0;
    end else begin
      state_q  <= state_d;
      ip_q     <= ip_d;
      sport_q  <= sport_d;
      dport_q  <= dport_d;
      len_q    <= len_d;
      exp_q    <= exp_d;
      cnt_q    <= cnt_d;
      to_q     <= to_d;
      frames_q <= frames_d;
      errors_q <= errors_d;
      drops_q  <= drops_d;
    end
  end

  assign m_ip_dest_ip      = ip_q;
  assign m_udp_source_port = sport_q;
  assign m_udp_dest_port   = dport_q;
  assign m_udp_length      = len_q;
  assign m_udp_checksum    = 16'h0000;
  assign stat_frames       = frames_q;
  assign stat_errors       = errors_q;
  assign stat_drops        = drops_q;

endmodule

// File: tb/tb_pcm_udp_framer.sv
// Bench for pcm_udp_framer: directed vector table, hand-written timeout/reset/backpressure
// sequences, and random frames scored against a frame-level reference model.
module tb_pcm_udp_framer;
  localparam int MAXP = 1472;
  localparam int TO   = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        s_hdr_valid = 1'b0;
  logic        s_hdr_ready;
  logic [15:0] s_length = '0;
  logic [7:0]  s_tdata = '0;
  logic        s_tvalid = 1'b0;
  logic        s_tready;
  logic        s_tlast = 1'b0;
  logic        m_udp_hdr_valid;
  logic        m_udp_hdr_ready = 1'b1;
  logic [31:0] m_ip_dest_ip;
  logic [15:0] m_udp_source_port;
  logic [15:0] m_udp_dest_port;
  logic [15:0] m_udp_length;
  logic [15:0] m_udp_checksum;
  logic [7:0]  m_tdata;
  logic        m_tvalid;
  logic        m_tready = 1'b0;
  logic        m_tlast;
  logic        m_tuser;
  logic        cfg_enable = 1'b0;
  logic [31:0] cfg_dest_ip = '0;
  logic [15:0] cfg_dest_port = '0;
  logic [15:0] cfg_src_port = '0;
  logic [31:0] stat_frames;
  logic [15:0] stat_errors;
  logic [15:0] stat_drops;

  always #5 clk = ~clk;

  pcm_udp_framer #(.MAX_PAYLOAD(MAXP), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .s_hdr_valid(s_hdr_valid), .s_hdr_ready(s_hdr_ready), .s_length(s_length),
    .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tlast(s_tlast),
    .m_udp_hdr_valid(m_udp_hdr_valid), .m_udp_hdr_ready(m_udp_hdr_ready),
    .m_ip_dest_ip(m_ip_dest_ip), .m_udp_source_port(m_udp_source_port),
    .m_udp_dest_port(m_udp_dest_port), .m_udp_length(m_udp_length),
    .m_udp_checksum(m_udp_checksum),
    .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready),
    .m_tlast(m_tlast), .m_tuser(m_tuser),
    .cfg_enable(cfg_enable), .cfg_dest_ip(cfg_dest_ip),
    .cfg_dest_port(cfg_dest_port), .cfg_src_port(cfg_src_port),
    .stat_frames(stat_frames), .stat_errors(stat_errors), .stat_drops(stat_drops)
  );

  typedef struct { logic [7:0] data; logic last; logic user; } beat_t;
  typedef struct { logic [31:0] ip; logic [15:0] sp; logic [15:0] dp; logic [15:0] len; } hdr_t;
  typedef struct { int len; bit en; int n; int beats; bit user; int hdr; } vec_t;

  beat_t got_q[$];
  beat_t exp_q[$];
  hdr_t  got_h[$];
  beat_t mon_b;
  hdr_t  mon_h;
  logic [7:0] pay [0:2047];
  int    n_checks = 0;
  int    n_err = 0;
  int    rdy_mode = 0;
  int    mirror_bad = 0;
  int    exp_hdr_n = 0;
  longint m_frames = 0, m_errors = 0, m_drops = 0;

  // Output monitor: mid-cycle sampling sees the values the next edge will register.
  always @(negedge clk) begin
    if (!rst) begin
      if (m_tvalid && m_tready) begin
        mon_b.data = m_tdata; mon_b.last = m_tlast; mon_b.user = m_tuser;
        got_q.push_back(mon_b);
      end
      if (m_udp_hdr_valid && m_udp_hdr_ready) begin
        mon_h.ip = m_ip_dest_ip; mon_h.sp = m_udp_source_port;
        mon_h.dp = m_udp_dest_port; mon_h.len = m_udp_length;
        got_h.push_back(mon_h);
      end
      if (m_tvalid && (s_tready !== m_tready)) mirror_bad++;
    end
  end

  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       m_tready = 1'b1;
      1:       m_tready = ~m_tready;
      default: m_tready = 1'($urandom_range(1, 0));
    endcase
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
    end
  endtask

  // Frame-level reference: what a UDP stack should see for one upstream frame.
  task automatic model(input int len, input bit en, input int n);
    int exp_n, nout;
    beat_t b;
    exp_q.delete();
    if (!en || len < 9 || len - 8 > MAXP) begin
      exp_hdr_n = 0;
      m_drops++;
      return;
    end
    exp_hdr_n = 1;
    exp_n = len - 8;
    nout = (n < exp_n) ? n : exp_n;
    for (int i = 0; i < nout; i++) begin
      b.data = pay[i];
      b.last = (i == nout - 1);
      b.user = (i == nout - 1) && (n != exp_n);
      exp_q.push_back(b);
    end
    if (n == exp_n) m_frames++;
    else            m_errors++;
  endtask

  task automatic send_hdr(input logic [15:0] len, output bit ok);
    int guard = 0;
    s_hdr_valid = 1'b1;
    s_length = len;
    @(negedge clk);
    while (!s_hdr_ready && guard < 200) begin @(negedge clk); guard++; end
    ok = s_hdr_ready;
    @(posedge clk); #1;
    s_hdr_valid = 1'b0;
  endtask

  task automatic send_bytes(input int n, input int gap_max, input bit with_last, output bit ok);
    int guard;
    ok = 1'b1;
    for (int i = 0; i < n; i++) begin
      if (gap_max > 0) repeat ($urandom_range(gap_max, 0)) begin @(posedge clk); #1; end
      s_tvalid = 1'b1;
      s_tdata  = pay[i];
      s_tlast  = with_last && (i == n - 1);
      guard = 0;
      @(negedge clk);
      while (!s_tready && guard < 500) begin @(negedge clk); guard++; end
      if (!s_tready) ok = 1'b0;
      @(posedge clk); #1;
      s_tvalid = 1'b0;
      s_tlast  = 1'b0;
      if (!ok) break;
    end
  endtask

  task automatic check_stats();
    check("stat_frames", stat_frames, m_frames);
    check("stat_errors", stat_errors, m_errors);
    check("stat_drops", stat_drops, m_drops);
  endtask

  task automatic run_frame(input int len, input bit en, input int n, input int gap_max,
                           input int hdr_hold, input logic [15:0] dport, input bit rnd,
                           output int nbeats, output bit lastuser, output int nhdr);
    hdr_t eh;
    bit ok;
    int hold_bad, lim;
    got_q.delete();
    got_h.delete();
    cfg_enable    = en;
    cfg_dest_ip   = $urandom;
    cfg_src_port  = 16'($urandom);
    cfg_dest_port = dport;
    eh.ip = cfg_dest_ip; eh.sp = cfg_src_port; eh.dp = dport; eh.len = 16'(len);
    for (int i = 0; i < n; i++) pay[i] = rnd ? 8'($urandom) : 8'(i + 1);
    model(len, en, n);
    if (hdr_hold > 0) m_udp_hdr_ready = 1'b0;
    send_hdr(16'(len), ok);
    check("hdr_accept", ok, 1);
    cfg_dest_ip   = ~cfg_dest_ip;
    cfg_src_port  = ~cfg_src_port;
    cfg_dest_port = ~cfg_dest_port;
    cfg_enable    = ~cfg_enable;
    if (hdr_hold > 0) begin
      hold_bad = 0;
      repeat (hdr_hold) begin
        @(negedge clk);
        if (!m_udp_hdr_valid || m_udp_length !== eh.len || m_udp_dest_port !== eh.dp ||
            m_ip_dest_ip !== eh.ip || m_udp_source_port !== eh.sp) hold_bad++;
      end
      check("hdr_hold_stable", hold_bad, 0);
      @(posedge clk); #1;
      m_udp_hdr_ready = 1'b1;
    end
    send_bytes(n, gap_max, 1'b1, ok);
    check("payload_consumed", ok, 1);
    repeat (3) @(posedge clk);
    #1;
    check("hdr_count", got_h.size(), exp_hdr_n);
    if (exp_hdr_n == 1 && got_h.size() == 1) begin
      check("hdr_ip", got_h[0].ip, eh.ip);
      check("hdr_sport", got_h[0].sp, eh.sp);
      check("hdr_dport", got_h[0].dp, eh.dp);
      check("hdr_len", got_h[0].len, eh.len);
      check("hdr_csum", m_udp_checksum, 0);
    end
    check("beat_count", got_q.size(), exp_q.size());
    lim = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < lim; i++)
      check("beat_data_last_user", {got_q[i].data, got_q[i].last, got_q[i].user},
            {exp_q[i].data, exp_q[i].last, exp_q[i].user});
    check_stats();
    nbeats   = got_q.size();
    lastuser = (got_q.size() > 0) ? got_q[got_q.size() - 1].user : 1'b0;
    nhdr     = got_h.size();
  endtask

  vec_t tbl[9];
  int   nb, nh, idle, len, n, r;
  bit   lu, en, ok;

  initial begin
    tbl[0] = '{20,   1, 12,   12,   0, 1};
    tbl[1] = '{20,   1, 8,    8,    1, 1};
    tbl[2] = '{12,   1, 10,   4,    1, 1};
    tbl[3] = '{1332, 0, 1324, 0,    0, 0};
    tbl[4] = '{8,    0, 1,    0,    0, 0};
    tbl[5] = '{9,    1, 1,    1,    0, 1};
    tbl[6] = '{8,    1, 1,    0,    0, 0};
    tbl[7] = '{1480, 1, 1472, 1472, 0, 1};
    tbl[8] = '{1481, 1, 2,    0,    0, 0};

    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    check("rst_hdr_ready", s_hdr_ready, 1);
    check("rst_hdr_valid", m_udp_hdr_valid, 0);
    check("rst_tvalid", m_tvalid, 0);
    check("rst_tlast_tuser", {m_tlast, m_tuser}, 0);
    check("rst_tready", s_tready, 0);
    check("rst_fields", {m_ip_dest_ip, m_udp_length, m_udp_dest_port}, 0);
    check("rst_csum", m_udp_checksum, 0);
    check_stats();
    @(posedge clk); #1;
    rst = 1'b0;

    for (int k = 0; k < 9; k++) begin
      run_frame(tbl[k].len, tbl[k].en, tbl[k].n, (k < 3) ? 2 : 0, 0,
                (k == 0) ? 16'd5000 : 16'(1000 + k), 1'b0, nb, lu, nh);
      check("tbl_beats", nb, tbl[k].beats);
      check("tbl_hdr", nh, tbl[k].hdr);
      if (tbl[k].beats > 0) check("tbl_last_user", lu, tbl[k].user);
    end

    // Header backpressure then toggling m_tready.
    rdy_mode = 1;
    mirror_bad = 0;
    run_frame(20, 1'b1, 12, 2, 5, 16'd5000, 1'b1, nb, lu, nh);
    check("bp_beats", nb, 12);
    check("bp_mirror", mirror_bad, 0);

    // Timeout: three bytes then silence.
    rdy_mode = 0;
    @(posedge clk); #1;
    got_q.delete();
    cfg_enable = 1'b1;
    for (int i = 0; i < 12; i++) pay[i] = 8'(i + 1);
    send_hdr(16'd20, ok);
    check("to_hdr_accept", ok, 1);
    send_bytes(3, 0, 1'b0, ok);
    idle = 0;
    @(negedge clk);
    while (!m_tvalid && idle < 100) begin idle++; @(negedge clk); end
    check("to_idle_cycles", idle, TO);
    check("to_beat", {m_tdata, m_tlast, m_tuser}, {8'h00, 1'b1, 1'b1});
    m_errors++;
    @(negedge clk);
    check("to_drain_flags", {s_hdr_ready, s_tready, m_tvalid}, 3'b010);
    @(posedge clk); #1;
    send_bytes(9, 0, 1'b1, ok);
    repeat (2) @(posedge clk);
    #1;
    check("to_beat_count", got_q.size(), 4);
    check_stats();
    run_frame(20, 1'b1, 12, 0, 0, 16'd7, 1'b1, nb, lu, nh);

    // Random frames against the model.
    rdy_mode = 2;
    for (int f = 0; f < 40; f++) begin
      r = $urandom_range(9, 0);
      if (r == 0)      len = $urandom_range(8, 0);
      else if (r == 1) len = MAXP + 8 + $urandom_range(3, 1);
      else             len = $urandom_range(60, 9);
      en = ($urandom_range(9, 0) != 0);
      if (len < 9 || len > 70) n = $urandom_range(5, 1);
      else                     n = $urandom_range(len - 8 + 4, 1);
      run_frame(len, en, n, 3, 0, 16'($urandom), 1'b1, nb, lu, nh);
    end

    // Reset mid-payload.
    rdy_mode = 0;
    @(posedge clk); #1;
    cfg_enable = 1'b1;
    send_hdr(16'd20, ok);
    send_bytes(3, 0, 1'b0, ok);
    s_tvalid = 1'b1;
    s_tdata  = 8'h55;
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_pre_edge_tvalid", m_tvalid, 1);
    @(negedge clk);
    check("rst_mid_hdr_ready", s_hdr_ready, 1);
    check("rst_mid_outs", {m_tvalid, m_tlast, m_tuser, s_tready, m_udp_hdr_valid}, 0);
    check("rst_mid_fields", {m_ip_dest_ip, m_udp_length}, 0);
    m_frames = 0; m_errors = 0; m_drops = 0;
    check_stats();
    @(posedge clk); #1;
    rst = 1'b0;
    s_tvalid = 1'b0;
    run_frame(20, 1'b1, 12, 1, 0, 16'd5000, 1'b1, nb, lu, nh);
    check("post_rst_frame_beats", nb, 12);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end
endmodule
